// File: rtl/stream_block_arbiter_pkg.sv
// Shared types and sizing helpers for the two-requester block arbiter.
package stream_block_arbiter_pkg;

  localparam int unsigned NumReq = 2;

  typedef enum logic [1:0] {
    StIdle,
    StGrant0,
    StGrant1
  } state_e;

  // Counter width for a modulo-n counter; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/axis_output_register.sv
// One-deep valid/ready register stage; in_ready depends only on registered state and out_ready.
module axis_output_register #(
  parameter int unsigned Width = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [Width-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [Width-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready
);

  logic [Width-1:0] data_q;
  logic             valid_q;

  assign in_ready  = !valid_q || out_ready;
  assign out_data  = data_q;
  assign out_valid = valid_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else if (in_valid && in_ready) begin
      valid_q <= 1'b1;
      data_q  <= in_data;
    end else if (out_ready) begin
      valid_q <= 1'b0;
    end
  end

endmodule

// File: rtl/stream_block_arbiter.sv
// Round-robin arbiter granting one of two AXI streams for whole blocks of INPUT_BDIM beats,
// tagging block ends (tlast), source (tid) and frame ends (tuser).
module stream_block_arbiter
  import stream_block_arbiter_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned INPUT_BDIM = 16,
  parameter int unsigned INPUT_SDIM = 256
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst_n,
  input  logic [DATA_WIDTH-1:0] s_axis_in0_tdata,
  input  logic                  s_axis_in0_tvalid,
  output logic                  s_axis_in0_tready,
  input  logic [DATA_WIDTH-1:0] s_axis_in1_tdata,
  input  logic                  s_axis_in1_tvalid,
  output logic                  s_axis_in1_tready,
  output logic [DATA_WIDTH-1:0] m_axis_output_tdata,
  output logic                  m_axis_output_tvalid,
  input  logic                  m_axis_output_tready,
  output logic                  m_axis_output_tlast,
  output logic                  m_axis_output_tid,
  output logic                  m_axis_output_tuser
);

  localparam int unsigned SafeBdim = (INPUT_BDIM == 0) ? 1 : INPUT_BDIM;
  localparam int unsigned NumBlk   = INPUT_SDIM / SafeBdim;
  localparam int unsigned BeatW    = cnt_width(SafeBdim);
  localparam int unsigned BlkW     = cnt_width(NumBlk);
  localparam int unsigned PayW     = DATA_WIDTH + 3;

  if (INPUT_BDIM < 1 || INPUT_SDIM == 0 || (INPUT_SDIM % SafeBdim) != 0) begin : g_bad_dims
    $error("INPUT_SDIM must be a non-zero multiple of INPUT_BDIM (>=1)");
  end

  state_e          state_q, state_d;
  logic            rr_q, rr_d;
  logic [BeatW-1:0] beat_cnt_q, beat_cnt_d;
  logic [BlkW-1:0]  blk_cnt_q [NumReq];
  logic [BlkW-1:0]  blk_cnt_d [NumReq];

  logic                  gid, granted, sel_valid, reg_ready, accept;
  logic                  last_beat, frame_last;
  logic [DATA_WIDTH-1:0] sel_data;
  logic [PayW-1:0]       in_payload, out_payload;

  assign granted    = (state_q != StIdle);
  assign gid        = (state_q == StGrant1);
  assign sel_valid  = gid ? s_axis_in1_tvalid : s_axis_in0_tvalid;
  assign sel_data   = gid ? s_axis_in1_tdata : s_axis_in0_tdata;
  assign accept     = granted && sel_valid && reg_ready;
  assign last_beat  = (beat_cnt_q == BeatW'(SafeBdim - 1));
  assign frame_last = (blk_cnt_q[gid] == BlkW'(NumBlk - 1));
  assign in_payload = {sel_data, last_beat, gid, last_beat && frame_last};

  assign s_axis_in0_tready = (state_q == StGrant0) && reg_ready;
  assign s_axis_in1_tready = (state_q == StGrant1) && reg_ready;

  always_comb begin
    state_d    = state_q;
    rr_d       = rr_q;
    beat_cnt_d = beat_cnt_q;
    blk_cnt_d  = blk_cnt_q;
    case (state_q)
      StIdle: begin
        if (s_axis_in0_tvalid && (!s_axis_in1_tvalid || !rr_q)) begin
          state_d = StGrant0;
        end else if (s_axis_in1_tvalid) begin
          state_d = StGrant1;
        end
      end
      StGrant0, StGrant1: begin
        // Grant is held until the block completes; a stalled requester is never preempted.
        if (accept) begin
          if (last_beat) begin
            beat_cnt_d     = '0;
            state_d        = StIdle;
            rr_d           = !gid;
            blk_cnt_d[gid] = frame_last ? '0 : blk_cnt_q[gid] + BlkW'(1);
          end else begin
            beat_cnt_d = beat_cnt_q + BeatW'(1);
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      state_q    <= StIdle;
      rr_q       <= 1'b0;
      beat_cnt_q <= '0;
      for (int i = 0; i < NumReq; i++) blk_cnt_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      rr_q       <= rr_d;
      beat_cnt_q <= beat_cnt_d;
      blk_cnt_q  <= blk_cnt_d;
    end
  end

  axis_output_register #(
    .Width(PayW)
  ) u_out_reg (
    .clk      (ap_clk),
    .rst_n    (ap_rst_n),
    .in_data  (in_payload),
    .in_valid (accept),
    .in_ready (reg_ready),
    .out_data (out_payload),
    .out_valid(m_axis_output_tvalid),
    .out_ready(m_axis_output_tready)
  );

  assign m_axis_output_tdata = out_payload[PayW-1:3];
  assign m_axis_output_tlast = out_payload[2];
  assign m_axis_output_tid   = out_payload[1];
  assign m_axis_output_tuser = out_payload[0];

endmodule
